// File: rtl/div_unit_pkg.sv
// Shared types for the iterative RV32M divider and its issue/write-back neighbours.
package div_unit_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_RD_W   = 5;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef struct packed {
    div_op_t               div_control;
    logic [DIV_RD_W-1:0]   rd;
    logic [DIV_DATA_W-1:0] rs1;
    logic [DIV_DATA_W-1:0] rs2;
  } ix_div_inf_t;

  typedef struct packed {
    logic [DIV_RD_W-1:0]   rd;
    logic [DIV_DATA_W-1:0] result;
  } div_wb_inf_t;

  // Signed variants work on magnitudes and fix signs afterwards.
  function automatic logic is_signed_op(div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/div_unit_iter_core.sv
// Unsigned restoring divider datapath: one quotient bit per step.
module div_iter_core #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  logic [DATA_WIDTH-1:0] dvd;
  logic [DATA_WIDTH-1:0] dvs;
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH:0]   diff;
  logic                  q_bit;

  // Shift in the next dividend bit and trial-subtract; borrow bit decides the quotient bit.
  always_comb begin
    rem_shift = {rem, dvd[DATA_WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs};
    q_bit     = ~diff[DATA_WIDTH];
  end

  // Dividend register doubles as quotient shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
    end else if (start) begin
      dvd <= dividend;
      dvs <= divisor;
      rem <= '0;
    end else if (step) begin
      dvd <= {dvd[DATA_WIDTH-2:0], q_bit};
      rem <= q_bit ? diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
    end
  end

  assign quotient  = dvd;
  assign remainder = rem;

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider: FSM, sign/special-case handling and write-back handshake.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DIV_DATA_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ix_div_valid,
  input  ix_div_inf_t ix_div_inf,
  input  logic        wb_do_branch,
  input  logic        wb_div_ready,
  output logic        div_wb_valid,
  output div_wb_inf_t div_wb_inf,
  output logic        div_ix_done,
  output logic        div_busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]            state, state_nx;
  logic [CNT_W-1:0]      counter;
  div_op_t               op_q;
  logic [DIV_RD_W-1:0]   rd_q;
  logic                  q_neg_q, r_neg_q;

  logic [DATA_WIDTH-1:0] rs1_c, rs2_c, mag1_c, mag2_c;
  logic [DATA_WIDTH-1:0] special_res_c, fix_res_c;
  logic [DATA_WIDTH-1:0] q_core, r_core;
  logic                  sgn_c, s1_c, s2_c, div0_c, ovf_c;
  logic                  accept_c, special_c, core_step_c, wb_accept_c, last_step_c;

  // Operand decode: magnitudes, result signs and special-case results for the incoming op.
  always_comb begin
    rs1_c         = DATA_WIDTH'(ix_div_inf.rs1);
    rs2_c         = DATA_WIDTH'(ix_div_inf.rs2);
    sgn_c         = is_signed_op(ix_div_inf.div_control);
    s1_c          = sgn_c & rs1_c[DATA_WIDTH-1];
    s2_c          = sgn_c & rs2_c[DATA_WIDTH-1];
    mag1_c        = s1_c ? -rs1_c : rs1_c;
    mag2_c        = s2_c ? -rs2_c : rs2_c;
    div0_c        = (rs2_c == '0);
    ovf_c         = sgn_c && (rs1_c == MIN_NEG) && (rs2_c == '1);
    special_res_c = '0;
    if (div0_c) begin
      special_res_c = ((ix_div_inf.div_control == DIV) || (ix_div_inf.div_control == DIVU)) ? '1 : rs1_c;
    end else if (ovf_c) begin
      special_res_c = (ix_div_inf.div_control == DIV) ? MIN_NEG : '0;
    end
  end

  // Sign fix-up of the core's magnitude results and q/r selection.
  always_comb begin
    fix_res_c = '0;
    if ((op_q == DIV) || (op_q == DIVU)) begin
      fix_res_c = q_neg_q ? -q_core : q_core;
    end else begin
      fix_res_c = r_neg_q ? -r_core : r_core;
    end
  end

  // Next-state logic; a flush overrides every other input.
  always_comb begin
    state_nx    = state;
    accept_c    = 1'b0;
    special_c   = 1'b0;
    core_step_c = 1'b0;
    wb_accept_c = 1'b0;
    last_step_c = (counter == CNT_W'(DATA_WIDTH - 1));
    if (wb_do_branch) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (ix_div_valid) begin
            accept_c = 1'b1;
            if (div0_c || ovf_c) begin
              special_c = 1'b1;
              state_nx  = S_DONE;
            end else begin
              state_nx  = S_CALC;
            end
          end
        end
        S_CALC: begin
          core_step_c = 1'b1;
          if (last_step_c) state_nx = S_FIX;
        end
        S_FIX:  state_nx = S_DONE;
        S_DONE: begin
          if (wb_div_ready) begin
            wb_accept_c = 1'b1;
            state_nx    = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Op context captured at accept; step counter for the iteration loop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter <= '0;
      op_q    <= DIV;
      rd_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (accept_c) begin
      counter <= '0;
      op_q    <= ix_div_inf.div_control;
      rd_q    <= ix_div_inf.rd;
      q_neg_q <= s1_c ^ s2_c;
      r_neg_q <= s1_c;
    end else if (core_step_c) begin
      counter <= counter + CNT_W'(1);
    end
  end

  // Registered outputs; payload only changes when a new result is produced.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_wb_valid <= 1'b0;
      div_wb_inf   <= '0;
      div_ix_done  <= 1'b0;
      div_busy     <= 1'b0;
    end else begin
      div_wb_valid <= (state_nx == S_DONE);
      div_busy     <= (state_nx != S_IDLE);
      div_ix_done  <= wb_accept_c;
      if (special_c) begin
        div_wb_inf.rd     <= ix_div_inf.rd;
        div_wb_inf.result <= DIV_DATA_W'(special_res_c);
      end else if ((state == S_FIX) && !wb_do_branch) begin
        div_wb_inf.rd     <= rd_q;
        div_wb_inf.result <= DIV_DATA_W'(fix_res_c);
      end
    end
  end

  div_iter_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_c),
    .step      (core_step_c),
    .dividend  (mag1_c),
    .divisor   (mag2_c),
    .quotient  (q_core),
    .remainder (r_core)
  );

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        ix_div_valid;
  ix_div_inf_t ix_div_inf;
  logic        wb_do_branch;
  logic        wb_div_ready;
  logic        div_wb_valid;
  div_wb_inf_t div_wb_inf;
  logic        div_ix_done;
  logic        div_busy;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ix_div_valid (ix_div_valid),
    .ix_div_inf   (ix_div_inf),
    .wb_do_branch (wb_do_branch),
    .wb_div_ready (wb_div_ready),
    .div_wb_valid (div_wb_valid),
    .div_wb_inf   (div_wb_inf),
    .div_ix_done  (div_ix_done),
    .div_busy     (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a single-cycle op; returns #1 after the accepting edge.
  task automatic issue(input div_op_t op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    ix_div_valid           = 1'b1;
    ix_div_inf.div_control = op;
    ix_div_inf.rd          = rd;
    ix_div_inf.rs1         = a;
    ix_div_inf.rs2         = b;
    tick();
    ix_div_valid           = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!div_wb_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input div_op_t op, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    wb_div_ready = 1'b1;
    issue(op, rd, a, b);
    wait_valid(lat);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, div_wb_inf.result, exp);
    chk({tag, " rd"}, 32'(div_wb_inf.rd), 32'(rd));
    tick();
    chk({tag, " done pulse"}, 32'(div_ix_done), 32'd1);
    chk({tag, " valid cleared"}, 32'(div_wb_valid), 32'd0);
    tick();
    chk({tag, " done single"}, 32'(div_ix_done), 32'd0);
    chk({tag, " idle"}, 32'(div_busy), 32'd0);
  endtask

  initial begin
    int lat;
    logic seen;
    rst          = 1'b0;
    ix_div_valid = 1'b0;
    ix_div_inf   = '0;
    wb_do_branch = 1'b0;
    wb_div_ready = 1'b0;
    #3;
    chk("reset valid", 32'(div_wb_valid), 32'd0);
    chk("reset busy", 32'(div_busy), 32'd0);
    chk("reset done", 32'(div_ix_done), 32'd0);
    chk("reset result", div_wb_inf.result, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Normal and signed/unsigned arithmetic
    run_op("div 100/7", DIV, 5'd1, 32'd100, 32'd7, 32'd14, 33);
    run_op("rem -7/2", REM, 5'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div -7/2", DIV, 5'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("remu ffffffff/16", REMU, 5'd4, 32'hFFFF_FFFF, 32'd16, 32'd15, 33);
    run_op("divu ffffffff/16", DIVU, 5'd5, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);
    run_op("div 7/-2", DIV, 5'd6, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem 7/-2", REM, 5'd7, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);

    // Special cases
    run_op("divu 5/0", DIVU, 5'd8, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem 5/0", REM, 5'd9, 32'd5, 32'd0, 32'd5, 0);
    run_op("div ovf", DIV, 5'd10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem ovf", REM, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // Back-pressure in DONE
    wb_div_ready = 1'b0;
    issue(DIV, 5'd12, 32'd100, 32'd7);
    wait_valid(lat);
    chk("stall latency", 32'(lat), 32'd33);
    for (int i = 0; i < 5; i++) begin
      chk("stall valid", 32'(div_wb_valid), 32'd1);
      chk("stall result", div_wb_inf.result, 32'd14);
      chk("stall rd", 32'(div_wb_inf.rd), 32'd12);
      chk("stall no done", 32'(div_ix_done), 32'd0);
      tick();
    end
    chk("stall valid held", 32'(div_wb_valid), 32'd1);
    wb_div_ready = 1'b1;
    tick();
    chk("stall done pulse", 32'(div_ix_done), 32'd1);
    chk("stall valid cleared", 32'(div_wb_valid), 32'd0);
    tick();
    chk("stall done single", 32'(div_ix_done), 32'd0);

    // Flush during CALC
    issue(DIV, 5'd13, 32'd100, 32'd7);
    repeat (9) tick();
    chk("calc busy", 32'(div_busy), 32'd1);
    wb_do_branch = 1'b1;
    tick();
    wb_do_branch = 1'b0;
    chk("flush calc busy", 32'(div_busy), 32'd0);
    chk("flush calc valid", 32'(div_wb_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | div_wb_valid | div_ix_done;
      tick();
    end
    chk("flush calc quiet", 32'(seen), 32'd0);
    run_op("after flush divu", DIVU, 5'd14, 32'd1000, 32'd10, 32'd100, 33);

    // Flush in DONE, same cycle as ready
    wb_div_ready = 1'b0;
    issue(DIVU, 5'd15, 32'd5, 32'd0);
    chk("flush done valid pre", 32'(div_wb_valid), 32'd1);
    wb_div_ready = 1'b1;
    wb_do_branch = 1'b1;
    tick();
    wb_do_branch = 1'b0;
    chk("flush done valid", 32'(div_wb_valid), 32'd0);
    chk("flush done no done", 32'(div_ix_done), 32'd0);
    tick();
    chk("flush done no done2", 32'(div_ix_done), 32'd0);
    run_op("after flush remu", REMU, 5'd16, 32'd17, 32'd5, 32'd2, 33);

    // Async reset mid-CALC
    issue(DIV, 5'd17, 32'd100, 32'd7);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("rst busy", 32'(div_busy), 32'd0);
    chk("rst valid", 32'(div_wb_valid), 32'd0);
    chk("rst done", 32'(div_ix_done), 32'd0);
    chk("rst result", div_wb_inf.result, 32'd0);
    chk("rst rd", 32'(div_wb_inf.rd), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    run_op("post rst div 9/3", DIV, 5'd18, 32'd9, 32'd3, 32'd3, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
